// File: rtl/add_rs_dispatch.sv
// Add/sub reservation station and single-issue dispatcher for exec unit 2.
// Holds issued ADD/SUB ops until both operands are valid. Snoops the result
// broadcast to wake waiting operands. Sends the lowest-index ready op to the
// exec unit whenever no op is in flight there.
module add_rs_dispatch #(
  parameter int DEPTH = 3,
  parameter int DW    = 8,
  parameter int TW    = 4
) (
  input  logic          clk2,
  input  logic          rst_n,
  input  logic          iss_valid,
  output logic          iss_ready,
  input  logic [3:0]    iss_func,
  input  logic [TW-1:0] iss_rd,
  input  logic [2:0]    iss_rob,
  input  logic          iss_v1,
  input  logic          iss_v2,
  input  logic [TW-1:0] iss_t1,
  input  logic [TW-1:0] iss_t2,
  input  logic [DW-1:0] iss_d1,
  input  logic [DW-1:0] iss_d2,
  input  logic          cdb_valid,
  input  logic [TW-1:0] cdb_tag,
  input  logic [DW-1:0] cdb_data,
  input  logic          ex_done,
  input  logic          flush,
  output logic          ex_b,
  output logic [DW-1:0] rs1_data,
  output logic [DW-1:0] rs2_data,
  output logic [3:0]    func,
  output logic [TW-1:0] rd,
  output logic [2:0]    rob_ind,
  output logic [2:0]    rs_index,
  output logic [2:0]    add_count
);

  typedef struct packed {
    logic          busy;
    logic [3:0]    func;
    logic [TW-1:0] rd;
    logic [2:0]    rob;
    logic          v1;
    logic [TW-1:0] t1;
    logic [DW-1:0] d1;
    logic          v2;
    logic [TW-1:0] t2;
    logic [DW-1:0] d2;
  } entry_t;

  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  entry_t        ent_q [DEPTH];
  entry_t        ent_d [DEPTH];
  logic          inflight_q, inflight_d;
  logic [2:0]    count_q, count_d;
  logic          ex_b_q, ex_b_d;
  logic [DW-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
  logic [3:0]    func_q, func_d;
  logic [TW-1:0] rd_q, rd_d;
  logic [2:0]    rob_q, rob_d, idx_q, idx_d;

  logic          alloc_found, disp_found;
  logic [2:0]    alloc_idx, disp_idx;
  logic          issue_acc, disp_go;

  // Ready and full are judged on registered state only, so a freshly woken
  // or freshly freed entry is only visible one cycle later.
  assign iss_ready = ({1'b0, count_q} < DEPTH_C);

  // Lowest free entry for allocation and lowest ready entry for dispatch.
  always_comb begin
    alloc_found = 1'b0;
    alloc_idx   = '0;
    disp_found  = 1'b0;
    disp_idx    = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!ent_q[i].busy) begin
        alloc_found = 1'b1;
        alloc_idx   = 3'(i);
      end
      if (ent_q[i].busy && ent_q[i].v1 && ent_q[i].v2) begin
        disp_found = 1'b1;
        disp_idx   = 3'(i);
      end
    end
  end

  // Entry updates (wakeup, dispatch free, issue write, flush) and dispatch capture.
  always_comb begin
    issue_acc  = iss_valid && iss_ready && alloc_found;
    // ex_done frees the exec unit in the same cycle, allowing back-to-back dispatch.
    disp_go    = disp_found && (!inflight_q || ex_done) && !flush;
    ex_b_d     = disp_go;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    func_d     = func_q;
    rd_d       = rd_q;
    rob_d      = rob_q;
    idx_d      = idx_q;
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      if (cdb_valid && ent_q[i].busy) begin
        if (!ent_q[i].v1 && ent_q[i].t1 == cdb_tag) begin
          ent_d[i].v1 = 1'b1;
          ent_d[i].d1 = cdb_data;
        end
        if (!ent_q[i].v2 && ent_q[i].t2 == cdb_tag) begin
          ent_d[i].v2 = 1'b1;
          ent_d[i].d2 = cdb_data;
        end
      end
      if (disp_go && disp_idx == 3'(i)) begin
        ent_d[i].busy = 1'b0;
        rs1_d  = ent_q[i].d1;
        rs2_d  = ent_q[i].d2;
        func_d = ent_q[i].func;
        rd_d   = ent_q[i].rd;
        rob_d  = ent_q[i].rob;
        idx_d  = 3'(i);
      end
      // A just-dispatched entry is still busy in ent_q, so it is never the alloc target.
      if (issue_acc && alloc_idx == 3'(i)) begin
        ent_d[i].busy = 1'b1;
        ent_d[i].func = iss_func;
        ent_d[i].rd   = iss_rd;
        ent_d[i].rob  = iss_rob;
        ent_d[i].t1   = iss_t1;
        ent_d[i].t2   = iss_t2;
        ent_d[i].v1   = iss_v1 || (cdb_valid && iss_t1 == cdb_tag);
        ent_d[i].d1   = iss_v1 ? iss_d1 : cdb_data;
        ent_d[i].v2   = iss_v2 || (cdb_valid && iss_t2 == cdb_tag);
        ent_d[i].d2   = iss_v2 ? iss_d2 : cdb_data;
      end
      if (flush) ent_d[i].busy = 1'b0;
    end
  end

  // Occupancy count and in-flight tracking; flush overrides everything.
  always_comb begin
    count_d    = count_q;
    inflight_d = inflight_q;
    if (flush) begin
      count_d    = '0;
      inflight_d = 1'b0;
    end else begin
      if (issue_acc && !disp_go)      count_d = count_q + 3'd1;
      else if (!issue_acc && disp_go) count_d = count_q - 3'd1;
      if (disp_go)      inflight_d = 1'b1;
      else if (ex_done) inflight_d = 1'b0;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      inflight_q <= 1'b0;
      count_q    <= '0;
      ex_b_q     <= 1'b0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      func_q     <= '0;
      rd_q       <= '0;
      rob_q      <= '0;
      idx_q      <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      inflight_q <= inflight_d;
      count_q    <= count_d;
      ex_b_q     <= ex_b_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      func_q     <= func_d;
      rd_q       <= rd_d;
      rob_q      <= rob_d;
      idx_q      <= idx_d;
    end
  end

  assign ex_b      = ex_b_q;
  assign rs1_data  = rs1_q;
  assign rs2_data  = rs2_q;
  assign func      = func_q;
  assign rd        = rd_q;
  assign rob_ind   = rob_q;
  assign rs_index  = idx_q;
  assign add_count = count_q;

endmodule
